// File: rtl/mole_game_core.sv
// mole_game_core: whack-a-mole game engine.
//   Round FSM (PREPARE / PLAY / END_TIMEOUT / END_WIN), countdown timer built
//   from a clk prescaler, LFSR-driven target spawner with SLOTS simultaneous
//   targets over NUM_HOLES holes, per-target lifetime and hit/miss/penalty scoring.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   btn_start      start/acknowledge button level (rising edge acts)
//   key            key levels, bit i = hole i pressed
//   state          1=PREPARE 2=PLAY 0=END_TIMEOUT 3=END_WIN
//   time_left      seconds remaining
//   score          current score
//   target_mask    bit i = live target at hole i
//   target_color   2-bit {R,G} per hole (point value), 0 where no target
//   boom_mask      bit i = hole i showing hit explosion
//   hit_pulse      one-cycle pulse per scored hit
//   miss_pulse     one-cycle pulse per cycle with at least one expiry
module mole_game_core #(
    parameter int NUM_HOLES     = 16,
    parameter int SLOTS         = 2,
    parameter int CYC_PER_TICK  = 1000,
    parameter int TICKS_PER_SEC = 1000,
    parameter int GAME_SECONDS  = 59,
    parameter int WIN_SCORE     = 19,
    parameter int LIFE_TICKS    = 1000,
    parameter int BOOM_TICKS    = 200,
    parameter int PENALTY       = 1,
    parameter int SCORE_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_start,
    input  logic [NUM_HOLES-1:0]   key,
    output logic [1:0]             state,
    output logic [7:0]             time_left,
    output logic [SCORE_W-1:0]     score,
    output logic [NUM_HOLES-1:0]   target_mask,
    output logic [2*NUM_HOLES-1:0] target_color,
    output logic [NUM_HOLES-1:0]   boom_mask,
    output logic                   hit_pulse,
    output logic                   miss_pulse
);

    localparam int POS_W   = $clog2(NUM_HOLES);
    localparam int CNT_MAX = (LIFE_TICKS > BOOM_TICKS) ? LIFE_TICKS : BOOM_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int CYC_W   = $clog2(CYC_PER_TICK + 1);
    localparam int TICK_W  = $clog2(TICKS_PER_SEC + 1);

    typedef enum logic [1:0] {
        ST_END_TIMEOUT = 2'd0,
        ST_PREPARE     = 2'd1,
        ST_PLAY        = 2'd2,
        ST_END_WIN     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SL_EMPTY = 2'd0,
        SL_UP    = 2'd1,
        SL_BOOM  = 2'd2
    } slot_e;

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input logic [1:0] b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + (SCORE_W + 1)'(b);
        return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
    endfunction

    function automatic logic [SCORE_W-1:0] sat_sub(input logic [SCORE_W-1:0] a);
        logic [SCORE_W-1:0] p;
        p = SCORE_W'(PENALTY);
        return (a >= p) ? (a - p) : {SCORE_W{1'b0}};
    endfunction

    state_e                 state_q, state_d;
    logic [7:0]             time_left_q, time_left_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [CYC_W-1:0]       cyc_cnt_q, cyc_cnt_d;
    logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic                   btn_q, btn_d;
    logic [NUM_HOLES-1:0]   key_r_q, key_r_d, key_rr_q, key_rr_d;
    logic                   press_q, press_d;
    logic [POS_W-1:0]       press_idx_q, press_idx_d;
    slot_e                  slot_st_q  [SLOTS];
    slot_e                  slot_st_d  [SLOTS];
    logic [POS_W-1:0]       slot_pos_q [SLOTS];
    logic [POS_W-1:0]       slot_pos_d [SLOTS];
    logic [1:0]             slot_col_q [SLOTS];
    logic [1:0]             slot_col_d [SLOTS];
    logic [CNT_W-1:0]       slot_cnt_q [SLOTS];
    logic [CNT_W-1:0]       slot_cnt_d [SLOTS];
    logic [NUM_HOLES-1:0]   target_mask_q, target_mask_d;
    logic [2*NUM_HOLES-1:0] target_color_q, target_color_d;
    logic [NUM_HOLES-1:0]   boom_mask_q, boom_mask_d;
    logic                   hit_pulse_q, hit_pulse_d;
    logic                   miss_pulse_q, miss_pulse_d;

    logic                   btn_rise_s, in_play_s, active_s, tick_s, sec_s;
    logic                   hit_any_s, miss_any_s, seen_empty_s, pos_busy_s;
    logic [1:0]             hit_col_s, new_col_s;
    logic [POS_W-1:0]       new_pos_s;

    // Next-state logic for FSM, timers, key path, slots, score and outputs
    always_comb begin
        btn_d      = btn_start;
        btn_rise_s = btn_start & ~btn_q;
        lfsr_d     = lfsr_next(lfsr_q);
        key_r_d    = key;
        key_rr_d   = key_r_q;
        // a press is a single fresh key: exactly one bit now, nothing the cycle before
        press_d     = $onehot(key_r_q) && (key_rr_q == {NUM_HOLES{1'b0}});
        press_idx_d = {POS_W{1'b0}};
        for (int i = 0; i < NUM_HOLES; i++) begin
            press_idx_d = press_idx_d | (key_r_q[i] ? POS_W'(i) : {POS_W{1'b0}});
        end

        // prescaler runs only in PLAY so the first second is full length
        in_play_s = (state_q == ST_PLAY);
        tick_s    = in_play_s && (cyc_cnt_q == CYC_W'(CYC_PER_TICK - 1));
        sec_s     = tick_s && (tick_cnt_q == TICK_W'(TICKS_PER_SEC - 1));
        if (!in_play_s || tick_s) begin
            cyc_cnt_d = {CYC_W{1'b0}};
        end else begin
            cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        end
        if (!in_play_s || sec_s) begin
            tick_cnt_d = {TICK_W{1'b0}};
        end else if (tick_s) begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end else begin
            tick_cnt_d = tick_cnt_q;
        end

        state_d     = state_q;
        time_left_d = time_left_q;
        case (state_q)
            ST_PREPARE: begin
                time_left_d = 8'(GAME_SECONDS);
                if (btn_rise_s) state_d = ST_PLAY;
                else            state_d = ST_PREPARE;
            end
            ST_PLAY: begin
                if (sec_s && (time_left_q != 8'd0)) time_left_d = time_left_q - 8'd1;
                else                                 time_left_d = time_left_q;
                // timeout wins over a simultaneous win
                if (time_left_q == 8'd0)                    state_d = ST_END_TIMEOUT;
                else if (score_q >= SCORE_W'(WIN_SCORE))    state_d = ST_END_WIN;
                else                                        state_d = ST_PLAY;
            end
            ST_END_TIMEOUT: begin
                time_left_d = 8'd0;
                if (btn_rise_s) state_d = ST_PREPARE;
                else            state_d = ST_END_TIMEOUT;
            end
            ST_END_WIN: begin
                if (btn_rise_s) state_d = ST_PREPARE;
                else            state_d = ST_END_WIN;
            end
            default: begin
                state_d = ST_PREPARE;
            end
        endcase

        // slots and score only evolve while the round stays in PLAY
        active_s  = in_play_s && (state_d == ST_PLAY);
        new_pos_s = lfsr_q[POS_W-1:0];
        new_col_s = {lfsr_q[15], ~lfsr_q[15] | lfsr_q[14]};
        pos_busy_s = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            pos_busy_s = pos_busy_s | ((slot_st_q[i] != SL_EMPTY) && (slot_pos_q[i] == new_pos_s));
        end

        hit_any_s    = 1'b0;
        miss_any_s   = 1'b0;
        hit_col_s    = 2'b00;
        seen_empty_s = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            slot_st_d[i]  = slot_st_q[i];
            slot_pos_d[i] = slot_pos_q[i];
            slot_col_d[i] = slot_col_q[i];
            slot_cnt_d[i] = slot_cnt_q[i];
            if (!active_s) begin
                slot_st_d[i]  = SL_EMPTY;
                slot_cnt_d[i] = {CNT_W{1'b0}};
            end else begin
                case (slot_st_q[i])
                    SL_UP: begin
                        // a hit beats an expiry in the same cycle
                        if (press_q && (press_idx_q == slot_pos_q[i])) begin
                            slot_st_d[i]  = SL_BOOM;
                            slot_cnt_d[i] = CNT_W'(BOOM_TICKS);
                            hit_any_s     = 1'b1;
                            hit_col_s     = slot_col_q[i];
                        end else if (tick_s) begin
                            if (slot_cnt_q[i] <= CNT_W'(1)) begin
                                slot_st_d[i] = SL_EMPTY;
                                miss_any_s   = 1'b1;
                            end else begin
                                slot_cnt_d[i] = slot_cnt_q[i] - CNT_W'(1);
                            end
                        end else begin
                            slot_cnt_d[i] = slot_cnt_q[i];
                        end
                    end
                    SL_BOOM: begin
                        if (tick_s) begin
                            if (slot_cnt_q[i] <= CNT_W'(1)) slot_st_d[i]  = SL_EMPTY;
                            else                            slot_cnt_d[i] = slot_cnt_q[i] - CNT_W'(1);
                        end else begin
                            slot_cnt_d[i] = slot_cnt_q[i];
                        end
                    end
                    SL_EMPTY: begin
                        // only the lowest empty slot may spawn; a busy position skips this tick
                        if (!seen_empty_s) begin
                            seen_empty_s = 1'b1;
                            if (tick_s && !pos_busy_s) begin
                                slot_st_d[i]  = SL_UP;
                                slot_pos_d[i] = new_pos_s;
                                slot_col_d[i] = new_col_s;
                                slot_cnt_d[i] = CNT_W'(LIFE_TICKS);
                            end else begin
                                slot_st_d[i] = SL_EMPTY;
                            end
                        end else begin
                            slot_st_d[i] = SL_EMPTY;
                        end
                    end
                    default: begin
                        slot_st_d[i] = SL_EMPTY;
                    end
                endcase
            end
        end

        hit_pulse_d  = hit_any_s;
        miss_pulse_d = miss_any_s;
        if (state_q == ST_PREPARE) begin
            score_d = {SCORE_W{1'b0}};
        end else if (active_s && press_q) begin
            if (hit_any_s) score_d = sat_add(score_q, hit_col_s);
            else           score_d = sat_sub(score_q);
        end else begin
            score_d = score_q;
        end

        target_mask_d  = {NUM_HOLES{1'b0}};
        target_color_d = {(2*NUM_HOLES){1'b0}};
        boom_mask_d    = {NUM_HOLES{1'b0}};
        for (int i = 0; i < SLOTS; i++) begin
            case (slot_st_d[i])
                SL_UP: begin
                    target_mask_d[slot_pos_d[i]]                 = 1'b1;
                    target_color_d[{slot_pos_d[i], 1'b0} +: 2] = slot_col_d[i];
                end
                SL_BOOM: begin
                    boom_mask_d[slot_pos_d[i]] = 1'b1;
                end
                default: begin
                    boom_mask_d = boom_mask_d;
                end
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_PREPARE;
            time_left_q    <= 8'(GAME_SECONDS);
            score_q        <= {SCORE_W{1'b0}};
            lfsr_q         <= 16'h0001;
            cyc_cnt_q      <= {CYC_W{1'b0}};
            tick_cnt_q     <= {TICK_W{1'b0}};
            btn_q          <= 1'b0;
            key_r_q        <= {NUM_HOLES{1'b0}};
            key_rr_q       <= {NUM_HOLES{1'b0}};
            press_q        <= 1'b0;
            press_idx_q    <= {POS_W{1'b0}};
            target_mask_q  <= {NUM_HOLES{1'b0}};
            target_color_q <= {(2*NUM_HOLES){1'b0}};
            boom_mask_q    <= {NUM_HOLES{1'b0}};
            hit_pulse_q    <= 1'b0;
            miss_pulse_q   <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_st_q[i]  <= SL_EMPTY;
                slot_pos_q[i] <= {POS_W{1'b0}};
                slot_col_q[i] <= 2'b00;
                slot_cnt_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            state_q        <= state_d;
            time_left_q    <= time_left_d;
            score_q        <= score_d;
            lfsr_q         <= lfsr_d;
            cyc_cnt_q      <= cyc_cnt_d;
            tick_cnt_q     <= tick_cnt_d;
            btn_q          <= btn_d;
            key_r_q        <= key_r_d;
            key_rr_q       <= key_rr_d;
            press_q        <= press_d;
            press_idx_q    <= press_idx_d;
            target_mask_q  <= target_mask_d;
            target_color_q <= target_color_d;
            boom_mask_q    <= boom_mask_d;
            hit_pulse_q    <= hit_pulse_d;
            miss_pulse_q   <= miss_pulse_d;
            for (int i = 0; i < SLOTS; i++) begin
                slot_st_q[i]  <= slot_st_d[i];
                slot_pos_q[i] <= slot_pos_d[i];
                slot_col_q[i] <= slot_col_d[i];
                slot_cnt_q[i] <= slot_cnt_d[i];
            end
        end
    end

    assign state        = state_q;
    assign time_left    = time_left_q;
    assign score        = score_q;
    assign target_mask  = target_mask_q;
    assign target_color = target_color_q;
    assign boom_mask    = boom_mask_q;
    assign hit_pulse    = hit_pulse_q;
    assign miss_pulse   = miss_pulse_q;

endmodule

// File: tb/tb_mole_game_core.sv
// Directed bench for mole_game_core: a main instance (WIN_SCORE=19) and a
// win instance (WIN_SCORE=3) share all inputs. Expected spawn position/color
// comes from an independent model of the specified LFSR.
module tb_mole_game_core;

    localparam int NH = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            btn_start = 1'b0;
    logic [NH-1:0]   key = '0;

    logic [1:0]      state_a, state_w;
    logic [7:0]      tl_a, tl_w;
    logic [7:0]      score_a, score_w;
    logic [NH-1:0]   tmask_a, tmask_w, boom_a, boom_w;
    logic [2*NH-1:0] tcol_a, tcol_w;
    logic            hit_a, hit_w, miss_a, miss_w;

    int              n_checks = 0;
    int              n_fail = 0;
    bit              miss_seen;
    logic [15:0]     lfsr_m;

    mole_game_core #(.NUM_HOLES(NH), .SLOTS(2), .CYC_PER_TICK(2), .TICKS_PER_SEC(10),
        .GAME_SECONDS(3), .WIN_SCORE(19), .LIFE_TICKS(8), .BOOM_TICKS(3), .PENALTY(1),
        .SCORE_W(8)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .key(key),
        .state(state_a), .time_left(tl_a), .score(score_a), .target_mask(tmask_a),
        .target_color(tcol_a), .boom_mask(boom_a), .hit_pulse(hit_a), .miss_pulse(miss_a));

    mole_game_core #(.NUM_HOLES(NH), .SLOTS(2), .CYC_PER_TICK(2), .TICKS_PER_SEC(10),
        .GAME_SECONDS(3), .WIN_SCORE(3), .LIFE_TICKS(8), .BOOM_TICKS(3), .PENALTY(1),
        .SCORE_W(8)) dut_win (
        .clk(clk), .rst(rst), .btn_start(btn_start), .key(key),
        .state(state_w), .time_left(tl_w), .score(score_w), .target_mask(tmask_w),
        .target_color(tcol_w), .boom_mask(boom_w), .hit_pulse(hit_w), .miss_pulse(miss_w));

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return {v[14:0], fb};
    endfunction

    function automatic logic [NH-1:0] hole(input int p);
        logic [NH-1:0] one;
        one = 1;
        return one << p;
    endfunction

    // Reference LFSR: seeded by reset, steps every clock
    always @(posedge clk) begin
        if (rst) lfsr_m <= 16'h0001;
        else     lfsr_m <= lfsr_step(lfsr_m);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (miss_a) miss_seen = 1'b1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          s;
        int          ws;
        bit          found;
        logic [15:0] c;

        // 1: reset and idle in PREPARE
        rst = 1'b1;
        steps(3);
        check_val("rst_state", state_a, 1);
        check_val("rst_time", tl_a, 3);
        check_val("rst_mask", tmask_a, 0);
        check_val("rst_color", tcol_a, 0);
        rst = 1'b0;
        steps(200);
        check_val("idle_state", state_a, 1);
        check_val("idle_time", tl_a, 3);
        check_val("idle_score", score_a, 0);
        check_val("idle_mask", tmask_a, 0);

        // 2: timeout round with no keys
        miss_seen = 1'b0;
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        check_val("play_state", state_a, 2);
        check_val("play_time0", tl_a, 3);
        steps(19);
        check_val("time_p20", tl_a, 3);
        step();
        check_val("time_p21", tl_a, 2);
        steps(20);
        check_val("time_p41", tl_a, 1);
        steps(20);
        check_val("time_p61", tl_a, 0);
        check_val("state_p61", state_a, 2);
        step();
        check_val("timeout_state", state_a, 0);
        check_val("timeout_time", tl_a, 0);
        check_val("miss_seen", miss_seen, 1);
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        step();
        check_val("back_prep_state", state_a, 1);
        check_val("back_prep_time", tl_a, 3);

        // 3/4/5: pick a start so the first spawn has color 3
        found = 1'b0;
        c = 16'h0000;
        for (int i = 0; i < 100 && !found; i++) begin
            c = lfsr_step(lfsr_step(lfsr_m));
            if (c[15:14] == 2'b11) found = 1'b1;
            else                   step();
        end
        check_val("color3_window", found, 1);
        s  = int'(c[3:0]);
        ws = s ^ 1;
        btn_start = 1'b1;
        step();                                   // P1
        btn_start = 1'b0;
        check_val("roundA_state", state_a, 2);
        key = hole(ws);                           // wrong key before any target
        step();                                   // P2
        key = '0;
        step();                                   // P3
        check_val("spawn_mask", tmask_a, hole(s));
        check_val("spawn_color", tcol_a, 32'(3) << (2 * s));
        key = hole(s);
        step();                                   // P4
        check_val("wrong_at_zero", score_a, 0);
        key = '0;
        step();                                   // P5
        key = hole(s);                            // later lands on the BOOM hole
        step();                                   // P6
        check_val("hit_score", score_a, 3);
        check_val("hit_pulse", hit_a, 1);
        check_val("hit_boom", boom_a, hole(s));
        check_val("hit_target_clr", tmask_a[s], 0);
        check_val("win_score", score_w, 3);
        key = '0;
        step();                                   // P7
        check_val("hit_pulse_end", hit_a, 0);
        check_val("win_state", state_w, 3);
        key = hole(s);
        step();                                   // P8
        check_val("boom_press_3to2", score_a, 2);
        key = '0;
        step();                                   // P9
        key = hole(s) | hole(ws);
        step();                                   // P10
        check_val("wrong_2to1", score_a, 1);
        check_val("boom_held", boom_a, hole(s));
        key = '0;
        step();                                   // P11
        check_val("boom_freed", boom_a, 0);
        step();                                   // P12
        check_val("multikey_nochange", score_a, 1);
        check_val("win_hold_score", score_w, 3);
        check_val("win_hold_state", state_w, 3);
        steps(18);                                // P30
        check_val("main_time_p30", tl_a, 2);
        check_val("win_time_frozen", tl_w, 3);

        // 6: reset mid-PLAY with two live targets
        found = 1'b0;
        for (int i = 0; i < 25 && !found; i++) begin
            if ($countones(tmask_a) == 2) found = 1'b1;
            else                          step();
        end
        check_val("two_targets", found, 1);
        check_val("pre_rst_play", state_a, 2);
        rst = 1'b1;
        step();
        check_val("midrst_state", state_a, 1);
        check_val("midrst_mask", tmask_a, 0);
        check_val("midrst_color", tcol_a, 0);
        check_val("midrst_boom", boom_a, 0);
        check_val("midrst_score", score_a, 0);
        check_val("midrst_time", tl_a, 3);
        rst = 1'b0;
        step();
        check_val("post_rst_state", state_a, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
